// File: rtl/chan_cfg_loader_pkg.sv
// Shared constants and encodings for the channel configuration loader.
package chan_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ADDR    = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

endpackage

// File: rtl/chan_cfg_loader_if.sv
// Byte-stream input and configuration-bank output bundle of chan_cfg_loader.
// master: byte source / bank consumer; slave: the loader itself.
interface chan_cfg_loader_if #(
  parameter int unsigned CH_NO     = 4,
  parameter int unsigned CFG_BYTES = 10
);
  localparam int unsigned W = CFG_BYTES * 8;

  logic [7:0]          i_data;
  logic                i_valid;
  logic [CH_NO*W-1:0]  o_cfg;
  logic [CH_NO-1:0]    o_load;
  logic                o_busy;
  logic                o_err;
  logic [1:0]          o_err_code;

  modport master (
    output i_data, i_valid,
    input  o_cfg, o_load, o_busy, o_err, o_err_code
  );

  modport slave (
    input  i_data, i_valid,
    output o_cfg, o_load, o_busy, o_err, o_err_code
  );
endinterface

// File: rtl/chan_cfg_loader_gap_timer.sv
// cfg_gap_timer: inter-byte gap counter for an open configuration frame.
// Counts while enabled, clears on request, flags when TIMEOUT-1 is reached.
module cfg_gap_timer #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // Gap counter: cleared by any received byte, advances while a frame is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/chan_cfg_loader.sv
// chan_cfg_loader: decodes framed configuration commands
// (A5, addr, CFG_BYTES payload, XOR checksum) from a UART byte stream and
// commits each checksum-verified payload into its channel's config slot.
// Optional inter-byte timeout is enabled by defining CHAN_CFG_TIMEOUT_EN.
module chan_cfg_loader
  import chan_cfg_pkg::*;
#(
  parameter int unsigned CH_NO     = 4,
  parameter int unsigned CFG_BYTES = 10,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  chan_cfg_loader_if.slave  bus
);
  localparam int unsigned W        = CFG_BYTES * 8;
  localparam int unsigned CNT_W    = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(CFG_BYTES - 1);
  localparam logic [7:0]       ADDR_LIMIT = 8'(CH_NO);

  state_t             state;
  logic [3:0]         addr_q;
  logic [W-1:0]       staging;
  logic [7:0]         xor_q;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CH_NO*W-1:0] cfg_q;
  logic [CH_NO-1:0]   load_q;
  logic               err_q;
  err_code_t          err_code_q;
  logic               timeout_hit;

`ifdef CHAN_CFG_TIMEOUT_EN
  logic gap_expired;

  cfg_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .clr     (bus.i_valid | timeout_hit),
    .en      (state != ST_IDLE),
    .expired (gap_expired)
  );

  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout_hit = gap_expired && !bus.i_valid && (state != ST_IDLE);
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame decoder FSM with staging, running checksum and configuration bank.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      staging    <= '0;
      xor_q      <= '0;
      byte_cnt   <= '0;
      cfg_q      <= '0;
      load_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      load_q <= '0;
      err_q  <= 1'b0;
      if (timeout_hit) begin
        err_code_q <= ERR_TIMEOUT;
        err_q      <= 1'b1;
        state      <= ST_IDLE;
        staging    <= '0;
        xor_q      <= '0;
        byte_cnt   <= '0;
      end else if (bus.i_valid) begin
        case (state)
          ST_IDLE: begin
            if (bus.i_data == SYNC_BYTE) begin
              state <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            addr_q   <= bus.i_data[3:0];
            xor_q    <= bus.i_data;
            byte_cnt <= '0;
            if (bus.i_data >= ADDR_LIMIT) begin
              err_code_q <= ERR_ADDR;
              err_q      <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            staging  <= (staging << 8) | W'(bus.i_data);
            xor_q    <= xor_q ^ bus.i_data;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_IDX) begin
              state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (xor_q == bus.i_data) begin
              for (int unsigned ch = 0; ch < CH_NO; ch++) begin
                if (addr_q == 4'(ch)) begin
                  cfg_q[ch*W +: W] <= staging;
                  load_q[ch]       <= 1'b1;
                end
              end
              err_code_q <= ERR_NONE;
            end else begin
              err_code_q <= ERR_CSUM;
              err_q      <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_cfg      = cfg_q;
  assign bus.o_load     = load_q;
  assign bus.o_busy     = (state != ST_IDLE);
  assign bus.o_err      = err_q;
  assign bus.o_err_code = err_code_q;
endmodule

// File: doc/chan_cfg_loader.md
# chan_cfg_loader

Receives framed configuration commands as a byte stream from the UART receiver and loads per-channel configuration words for the capture channels. Each frame carries a channel index, a fixed-length payload and an XOR checksum. Payloads are staged internally and committed to that channel's configuration slot only when the checksum is good. The block sits between `uart_rx` and the `channel` instances and replaces ad-hoc shift-register configuration.

## Interface
- `CH_NO`, 4, number of channel configuration slots (1..16)
- `CFG_BYTES`, 10, payload bytes per frame; slot width W = CFG_BYTES*8
- `TIMEOUT`, 50000, maximum inter-byte gap in `i_clk` cycles while a frame is open
- `i_clk`  in  1  system clock; all logic is on the rising edge
- `i_rst`  in  1  reset, asynchronous and active-high
- `i_data`  in  8  received byte
- `i_valid`  in  1  one-cycle strobe; `i_data` is valid in this cycle
- `o_cfg`  out  CH_NO*W  configuration bank; slot ch is `o_cfg[ch*W +: W]`
- `o_load`  out  CH_NO  one-cycle pulse on bit ch when slot ch is updated
- `o_busy`  out  1  high while a frame is open (state is not IDLE)
- `o_err`  out  1  one-cycle pulse when a frame is rejected
- `o_err_code`  out  2  last error: 0 none, 1 bad address, 2 bad checksum, 3 timeout

## Operation
- Frame format: `0xA5` sync, then address byte, then CFG_BYTES payload bytes, then checksum byte.
- Checksum rule: XOR of the address byte and all payload bytes equals the checksum byte. The sync byte is not included.
- FSM states: IDLE, ADDR, PAYLOAD, CSUM.
- IDLE: `i_valid` with `0xA5` moves to ADDR. Any other byte is ignored silently and raises no error.
- ADDR: store the address byte and start the running XOR with it.
  - If the address is ≥ CH_NO: set error code 1, pulse `o_err`, return to IDLE.
  - Otherwise: move to PAYLOAD with the byte counter at 0.
- PAYLOAD: shift each byte into a W-bit staging register, MSB-first, so the first byte lands in bits [W-1:W-8]. Update the running XOR and increment the counter. After byte CFG_BYTES-1, move to CSUM.
  - A `0xA5` byte inside a frame is ordinary data.
- CSUM: compare the running XOR with `i_data` combinationally.
  - Equal: copy staging into slot `addr`, pulse `o_load[addr]`, set `o_err_code` to 0.
  - Not equal: set code 2 and pulse `o_err`. The bank is unchanged.
  - Either way, return to IDLE.
- `o_err_code` is sticky until the next error or the next good commit.
- Only a good frame ever changes the bank. Slots other than `addr` are never modified.

## Timing
- Reset values:
  - all-zero: `o_cfg`, `o_load`, `o_busy`, `o_err`, `o_err_code`, staging register, XOR, counters
  - state: IDLE
- Reset mid-frame discards the partial frame. The bank also returns to zero.
- Commit latency: checksum `i_valid` in cycle t → updated slot and `o_load` pulse both visible in cycle t+1. `o_busy` is low in t+1.
- Error latency: the rejecting `i_valid` (or the timeout expiry) in cycle t → `o_err` pulse and new code in t+1.
- Back-to-back operation:
  - A sync byte in the cycle right after the checksum cycle is accepted; no dead cycle is required.
  - `i_valid` may be asserted on consecutive cycles.
- `o_busy` rises in the cycle after the accepted sync byte.

## Configuration
- `CHAN_CFG_TIMEOUT_EN` defined:
  - A gap counter clears on every `i_valid` and counts while state ≠ IDLE.
  - When it reaches TIMEOUT-1 with no byte: set code 3, pulse `o_err`, return to IDLE, discard staging.
  - If `i_valid` arrives in that same cycle, the byte wins and no timeout occurs.
- Not defined: no counter and no code 3. An open frame waits indefinitely.

## Structure
- Shared package `chan_cfg_pkg` holds:
  - sync byte constant `0xA5`
  - FSM state encoding
  - error code constants (NONE, ADDR, CSUM, TIMEOUT)
- One sub-module: `cfg_gap_timer` (counter, clear, expiry flag). It is instantiated only under `CHAN_CFG_TIMEOUT_EN`.
- The rest is a single FSM with staging and bank registers.

## Test plan
- Good frame: send `A5 02 01 02 03 04 05 06 07 08 09 0A 09` (defaults).
  - Expect slot 2 = `0x0102030405060708090A`, `o_load` = `4'b0100` for one cycle, code 0, other slots 0.
- Bad checksum: same frame with last byte `0x08`.
  - Expect `o_err` pulse, code 2, no `o_load`, slot 2 unchanged.
- Bad address: send `A5 07`.
  - Expect `o_err` pulse and code 1 one cycle after the `07` byte.
  - A following good frame to slot 0 commits correctly.
- Noise and embedded sync:
  - Send `00 FF` then a frame to slot 1 whose payload contains `A5` (checksum adjusted).
  - Expect no error and slot 1 loaded with the `A5` byte in place.
- Timeout (macro on, TIMEOUT=100): send `A5 01 11`, then idle for 100 cycles.
  - Expect `o_err`, code 3, `o_busy` low. A byte at exactly the expiry cycle prevents the timeout.
- Reset mid-frame: assert `i_rst` after 5 payload bytes.
  - Expect all outputs zero immediately. A subsequent full good frame commits normally.
